ours_fifo_rr_arb: RTL
=====================

Name: ours_fifo_rr_arb

Overview:
- Shares one buffered FIFO channel among N_REQ valid/ready requesters.
- A round-robin arbiter picks at most one requester per cycle and pushes its data, tagged with the source index, into an internal DEPTH-entry FIFO.
- A single valid/ready consumer drains the FIFO.
- Used wherever several producers (ring ports, miss queues) funnel into one downstream pipe.

Parameters:
- N_REQ, 4: number of requesters; legal range 2..16.
- WIDTH, 32: payload width per requester.
- DEPTH, 4: FIFO entries; 1 or a power of two. Any other value raises an elaboration error.
- SRC_W, $clog2(N_REQ): derived source-tag width; not overridden.
- CNT_W, $clog2(DEPTH+1): derived occupancy width; not overridden.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- arb_en  in  1  1 = arbitration allowed; 0 = no new grants (drain continues).
- req_valid  in  N_REQ  per-requester valid.
- req_data  in  N_REQ x WIDTH  per-requester payload, packed [N_REQ-1:0][WIDTH-1:0].
- req_ready  out  N_REQ  one-hot-or-zero grant; a transfer occurs on req_valid[i] & req_ready[i].
- out_valid  out  1  FIFO non-empty.
- out_data  out  WIDTH  head payload.
- out_src  out  SRC_W  head source index.
- out_ready  in  1  consumer accepts the head.
- occupancy  out  CNT_W  current entry count, 0..DEPTH.
- full  out  1  occupancy == DEPTH.

Behaviour:

Reset:
- rst is sampled at clk. While rst=1: req_ready=0, and the next state is flushed.
- After reset: occupancy=0, full=0, out_valid=0, rr_ptr=0.
- out_data and out_src are don't-care while out_valid=0.
- Reset mid-operation discards all stored entries. No output transfer occurs in a cycle where rst=1.

Arbitration (combinational, same cycle):
- eligible = req_valid & {N_REQ{arb_en & !full & !rst}}.
- Grant the first eligible index scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
- req_ready[i] = grant[i]. At most one bit is set.
- req_ready does not depend on out_ready: no write-through when full, even if a pop happens the same cycle.
- req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.

Pointer update:
- On a grant to index g: rr_ptr <= (g+1) mod N_REQ, including wrap from N_REQ-1 to 0.
- No grant: rr_ptr holds.
- Fairness: a continuously asserted request is granted within N_REQ grants.

FIFO:
- A push writes {g, req_data[g]} at the tail.
- Pop when out_valid & out_ready.
- Latency: data accepted at edge T appears at the head by T+1, when the FIFO was empty.
- Order is strictly FIFO across all sources.
- Push and pop in the same cycle: occupancy unchanged, both pointers advance.
- Push only: occupancy +1; full sets when it reaches DEPTH.
- Pop only: occupancy -1; out_valid clears when it reaches 0.
- Head and tail pointers wrap modulo DEPTH.
- DEPTH=1: a single register plus a valid flag, same semantics.

Hold and stability:
- out_data and out_src stay stable while out_valid=1 and out_ready=0.
- arb_en=0 blocks pushes only. Pops continue and rr_ptr holds.

Assertions (non-synthesis):
- No push when full.
- No pop when empty.
- req_ready is onehot0.
- occupancy <= DEPTH.

Test Plan:
1. Reset, then all four requesters valid with data 0xA0..0xA3, out_ready=1 -> grants in order 0,1,2,3,0. out_src follows 0,1,2,3 one cycle later; occupancy stays ≤1.
2. out_ready=0, requesters 1 and 3 valid, DEPTH=4 -> pushes src 1,3,1,3 and full=1 after 4 cycles. req_ready=0 thereafter. Raising out_ready pops 4 entries in push order and grants resume the cycle after full clears.
3. rr_ptr wrap: only requester 3 valid, one grant -> rr_ptr=0. Then requesters 0 and 3 valid -> requester 0 wins, then 3.
4. Full FIFO with out_ready=1 and req_valid=1 in the same cycle -> exactly one pop and no push. occupancy goes 4->3, and the push happens the next cycle.
5. arb_en=0 with 2 stored entries and all requests valid -> req_ready=0 and both entries drain. Re-enabling grants index rr_ptr first.
6. Assert rst with 3 entries stored mid-stream -> next cycle out_valid=0, occupancy=0, rr_ptr=0. With DEPTH=1, repeat scenario 1 -> identical ordering with full toggling each push.

Source files
------------

// File: rtl/ours_fifo_rr_arb.sv
// ---------------------------------------------------------------------------
// ours_fifo_rr_arb
//
// Several valid/ready producers share one buffered channel. Each cycle a
// round-robin arbiter grants at most one requester. The granted payload,
// tagged with its source index, is pushed into a DEPTH-entry FIFO. A single
// valid/ready consumer drains the FIFO.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous reset, active-high
//   arb_en     1 = new grants allowed; 0 = no grants, but draining continues
//   req_valid  per-requester valid            [N_REQ-1:0]
//   req_data   per-requester payload          [N_REQ-1:0][WIDTH-1:0]
//   req_ready  one-hot-or-zero grant          [N_REQ-1:0]
//   out_valid  FIFO holds at least one entry
//   out_data   payload at the head            [WIDTH-1:0]
//   out_src    source index at the head       [SRC_W-1:0]
//   out_ready  consumer accepts the head
//   occupancy  number of stored entries       [CNT_W-1:0]
//   full       occupancy == DEPTH
// ---------------------------------------------------------------------------
module ours_fifo_rr_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SRC_W = $clog2(N_REQ),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arb_en,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [SRC_W-1:0]            out_src,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            occupancy,
  output logic                        full
);

  // A one-entry FIFO still needs a pointer signal; it simply never moves.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Reject illegal configurations while elaborating rather than in silicon.
  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ours_fifo_rr_arb: DEPTH must be 1 or a power of two");
  end
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("ours_fifo_rr_arb: N_REQ must be in 2..16");
  end

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] rr_ptr_next;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [SRC_W:0]   scan_idx;
  logic             found;
  logic             push;
  logic             pop;

  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [SRC_W-1:0] mem_src  [DEPTH];

  // Advance a FIFO pointer, wrapping at DEPTH (works for DEPTH=1 too).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Grants are never issued while full, even if the head is popped this
  // cycle, so the ready path stays independent of out_ready.
  assign eligible = req_valid & {N_REQ{arb_en & ~full & ~rst}};

  // Round-robin scan starting at rr_ptr; the first eligible index wins.
  // scan_idx is one bit wider so rr_ptr + i cannot overflow before wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + (SRC_W + 1)'(i);
      if (scan_idx >= (SRC_W + 1)'(N_REQ)) begin
        scan_idx = scan_idx - (SRC_W + 1)'(N_REQ);
      end
      if (!found && eligible[scan_idx[SRC_W-1:0]]) begin
        found                        = 1'b1;
        grant[scan_idx[SRC_W-1:0]]   = 1'b1;
        grant_idx                    = scan_idx[SRC_W-1:0];
      end
    end
  end

  // The winner moves to lowest priority next time.
  assign rr_ptr_next = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  assign req_ready = grant;
  assign push      = found;
  assign pop       = out_valid & out_ready & ~rst;

  assign out_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign occupancy = count;
  assign out_data  = mem_data[head_ptr];
  assign out_src   = mem_src[head_ptr];

  // Control state: arbitration pointer, FIFO pointers and entry count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        rr_ptr   <= rr_ptr_next;
        tail_ptr <= ptr_inc(tail_ptr);
      end
      if (pop) begin
        head_ptr <= ptr_inc(head_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Payload storage needs no reset; the count decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[tail_ptr] <= req_data[grant_idx];
      mem_src[tail_ptr]  <= grant_idx;
    end
  end

  // Simulation-only sanity checks on the FIFO and grant invariants.
  a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst) !(pop && !out_valid));
  a_grant_onehot : assert property (@(posedge clk) $onehot0(req_ready));
  a_occ_bound    : assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));

endmodule
